// File: rtl/md_unit_ctrl.sv
// Multiply/divide controller for the EX stage: owns HI/LO, precomputes each
// mult/div result at accept and commits it after a fixed busy window.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] phi;
    logic [31:0] plo;
    logic        dzero;

    logic        md_start;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign md_start = Start && (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
    assign Stall    = Busy | md_start;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed division runs on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
    always_comb begin
        div_signed = (MDOp == OP_DIV);
        a_mag      = (div_signed && A[31]) ? (~A + 32'd1) : A;
        b_mag      = (div_signed && B[31]) ? (~B + 32'd1) : B;
        b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quot       = (div_signed && (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
        rem        = (div_signed && A[31]) ? (~r_mag + 32'd1) : r_mag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            phi   <= 32'd0;
            plo   <= 32'd0;
            dzero <= 1'b0;
            Busy  <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            OP_MULT, OP_MULTU: begin
                                phi   <= (MDOp == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                                plo   <= (MDOp == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                                dzero <= 1'b0;
                                cnt   <= 4'(MULT_CYCLES);
                                Busy  <= 1'b1;
                                state <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                phi   <= rem;
                                plo   <= quot;
                                dzero <= (B == 32'd0);
                                cnt   <= 4'(DIV_CYCLES);
                                Busy  <= 1'b1;
                                state <= DIV;
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (!dzero) begin
                            HI <= phi;
                            LO <= plo;
                        end
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: expected HI/LO pairs are queued when an op
// is issued and popped when its busy window closes.
module tb_md_unit_ctrl;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Stall (Stall),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        Start = start;
        MDOp  = op;
        A     = a;
        B     = b;
    endtask

    // Issue a command, check Stall in the accept cycle, then pass the accept edge.
    task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic expStall);
        applyStimulus(1'b1, op, a, b);
        #1;
        checkOutput("stall_accept", {31'd0, Stall}, {31'd0, expStall});
        step();
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    // Count remaining busy cycles (bounded), then compare HI/LO to the scoreboard.
    task automatic finishOp(input int expCycles);
        int   n;
        exp_t e;
        n = 0;
        while (Busy && n < 40) begin
            checkOutput("stall_busy", {31'd0, Stall}, 32'd1);
            n++;
            step();
        end
        checkOutput("busy_cycles", 32'(n), 32'(expCycles));
        if (sbq.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            checkOutput("commit_hi", HI, e.hi);
            checkOutput("commit_lo", LO, e.lo);
        end
    endtask

    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int cycles);
        sbq.push_back('{hi: eh, lo: el});
        startOp(op, a, b, 1'b1);
        finishOp(cycles);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
        step();
        step();
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("reset_busy", {31'd0, Busy}, 32'd0);
            checkOutput("reset_stall", {31'd0, Stall}, 32'd0);
            checkOutput("reset_hi", HI, 32'd0);
            checkOutput("reset_lo", LO, 32'd0);
        end

        $display("[TB] mult / multu");
        runOp(3'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        runOp(3'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);

        $display("[TB] div / divu");
        runOp(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        runOp(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        runOp(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);

        $display("[TB] divide by zero keeps HI/LO");
        startOp(3'd5, 32'h11, 32'd0, 1'b0);
        startOp(3'd6, 32'h22, 32'd0, 1'b0);
        checkOutput("mthi_preload", HI, 32'h11);
        checkOutput("mtlo_preload", LO, 32'h22);
        runOp(3'd3, 32'd5, 32'd0, 32'h11, 32'h22, 10);

        $display("[TB] commands ignored while busy");
        sbq.push_back('{hi: 32'h00000012, lo: 32'h34567800});
        startOp(3'd1, 32'h12345678, 32'h100, 1'b1);
        applyStimulus(1'b0, 3'd0, 32'hAAAA5555, 32'h5555AAAA);
        step();
        applyStimulus(1'b1, 3'd5, 32'hDEAD, 32'd3);
        step();
        applyStimulus(1'b0, 3'd0, 32'h0F0F0F0F, 32'd9);
        checkOutput("busy_hold_hi", HI, 32'h11);
        checkOutput("busy_hold_lo", LO, 32'h22);
        finishOp(3);
        startOp(3'd5, 32'h1234, 32'd0, 1'b0);
        checkOutput("mthi_after_commit", HI, 32'h1234);
        checkOutput("mthi_keeps_lo", LO, 32'h34567800);

        $display("[TB] back-to-back multu then divu");
        runOp(3'd2, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        runOp(3'd4, 32'd9, 32'd2, 32'd1, 32'd4, 10);

        $display("[TB] reset during div");
        startOp(3'd3, 32'd100, 32'd7, 1'b1);
        step();
        step();
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", {31'd0, Busy}, 32'd0);
        checkOutput("abort_hi", HI, 32'd0);
        checkOutput("abort_lo", LO, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) step();
        checkOutput("abort_stays_idle", {31'd0, Busy}, 32'd0);
        checkOutput("abort_no_commit_lo", LO, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
